// File: rtl/iir_pkg.sv
// iir_pkg: shared tap indices, FSM states and sizing helper for the biquad filter
package iir_pkg;
   localparam logic [2:0] TAP_B1 = 3'd0;
   localparam logic [2:0] TAP_B2 = 3'd1;
   localparam logic [2:0] TAP_B3 = 3'd2;
   localparam logic [2:0] TAP_A2 = 3'd3;
   localparam logic [2:0] TAP_A3 = 3'd4;
   typedef enum logic [1:0] {IDLE, MAC, WB} state_t;
   function automatic int acc_width(input int dw, input int cw);
      return dw + cw + 3;
   endfunction
endpackage

// File: rtl/iir_round_sat.sv
// iir_round_sat: round half up, drop fractional bits, saturate to the sample range
module iir_round_sat #(
   parameter int ACC_WIDTH   = 37,
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_SCALE = 14
) (
   input  logic signed [ACC_WIDTH-1:0]  acc,
   output logic signed [DATA_WIDTH-1:0] y
);
   localparam logic signed [ACC_WIDTH-1:0] HALF  = (ACC_WIDTH'(1) << COEFF_SCALE) >> 1;
   localparam logic signed [ACC_WIDTH-1:0] MAX_V = (ACC_WIDTH'(1) << (DATA_WIDTH-1)) - ACC_WIDTH'(1);
   localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;
   logic signed [ACC_WIDTH-1:0] r;
   always_comb begin
      r = (acc + HALF) >>> COEFF_SCALE;
      y = r > MAX_V ? MAX_V[DATA_WIDTH-1:0] : r < MIN_V ? MIN_V[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
   end
endmodule

// File: rtl/iir_biquad_mc.sv
// iir_biquad_mc: time-multiplexed multi-channel direct-form-I biquad with one shared MAC
module iir_biquad_mc
   import iir_pkg::*;
#(
   parameter int NCH         = 2,
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 18,
   parameter int COEFF_SCALE = 14
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sample_en,
   input  logic [NCH*DATA_WIDTH-1:0]     in,
   input  logic                          cfg_we,
   input  logic [$clog2(NCH*5)-1:0]      cfg_addr,
   input  logic signed [COEFF_WIDTH-1:0] cfg_data,
   output logic [NCH*DATA_WIDTH-1:0]     out,
   output logic                          out_valid,
   output logic                          busy,
   output logic                          overrun,
   output logic                          cfg_err
);
   localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEFF_WIDTH);
   localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
   localparam int CH_WIDTH   = NCH > 1 ? $clog2(NCH) : 1;
   localparam int AW         = $clog2(NCH*5);
   localparam logic [AW-1:0] NCOEF = AW'(NCH*5);
   localparam logic signed [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(1) << COEFF_SCALE;

   state_t                        state;
   logic [CH_WIDTH-1:0]           ch;
   logic [2:0]                    tap;
   logic signed [ACC_WIDTH-1:0]   acc, pext;
   logic signed [DATA_WIDTH-1:0]  x0[NCH], x1[NCH], x2[NCH], y1[NCH], y2[NCH];
   logic signed [COEFF_WIDTH-1:0] coef[NCH][5];
   logic signed [DATA_WIDTH-1:0]  sample, y_new;
   logic signed [PROD_WIDTH-1:0]  prod;
   logic                          cfg_ok;

   // the single multiplier: operand pair chosen by the current channel and tap
   always_comb begin
      sample = tap == TAP_B1 ? x0[ch] : tap == TAP_B2 ? x1[ch] : tap == TAP_B3 ? x2[ch] :
               tap == TAP_A2 ? y1[ch] : y2[ch];
      prod   = sample * coef[ch][tap];
      pext   = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
      cfg_ok = state == IDLE && cfg_addr < NCOEF;
   end

   assign busy = state != IDLE;

   iir_round_sat #(.ACC_WIDTH(ACC_WIDTH), .DATA_WIDTH(DATA_WIDTH), .COEFF_SCALE(COEFF_SCALE)) u_rs (
      .acc(acc),
      .y  (y_new)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++)
            for (int t = 0; t < 5; t++) coef[c][t] <= t == 0 ? UNITY : '0;
      end else if (cfg_we && cfg_ok) begin
         for (int c = 0; c < NCH; c++)
            for (int t = 0; t < 5; t++) if (cfg_addr == AW'(c*5 + t)) coef[c][t] <= cfg_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ch        <= '0;
         tap       <= '0;
         acc       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         cfg_err   <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            x0[c] <= '0;
            x1[c] <= '0;
            x2[c] <= '0;
            y1[c] <= '0;
            y2[c] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         overrun   <= sample_en && state != IDLE;
         cfg_err   <= cfg_we && !cfg_ok;
         case (state)
            IDLE: if (sample_en) begin
               state <= MAC;
               ch    <= '0;
               tap   <= '0;
               acc   <= '0;
               for (int c = 0; c < NCH; c++) x0[c] <= in[c*DATA_WIDTH +: DATA_WIDTH];
            end
            MAC: begin
               acc <= tap >= TAP_A2 ? acc - pext : acc + pext;
               tap <= tap + 3'd1;
               if (tap == TAP_A3) state <= WB;
            end
            WB: begin
               x2[ch] <= x1[ch];
               x1[ch] <= x0[ch];
               y2[ch] <= y1[ch];
               y1[ch] <= y_new;
               out[ch*DATA_WIDTH +: DATA_WIDTH] <= y_new;
               tap <= '0;
               acc <= '0;
               if (ch == CH_WIDTH'(NCH-1)) begin
                  state     <= IDLE;
                  out_valid <= 1'b1;
               end else begin
                  state <= MAC;
                  ch    <= ch + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iir_biquad_mc.sv
// tb_iir_biquad_mc: directed scoreboard bench for the two-channel biquad
module tb_iir_biquad_mc;
   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               sample_en = 1'b0;
   logic [31:0]        din = '0;
   logic               cfg_we = 1'b0;
   logic [3:0]         cfg_addr = '0;
   logic signed [17:0] cfg_data = '0;
   logic [31:0]        dout;
   logic               out_valid, busy, overrun, cfg_err;

   int n_assert = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];
   int mc[2][5];
   int mx1[2], mx2[2], my1[2], my2[2];

   iir_biquad_mc dut (
      .clk(clk), .reset(reset), .sample_en(sample_en), .in(din),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .out(dout), .out_valid(out_valid), .busy(busy), .overrun(overrun), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         for (int t = 0; t < 5; t++) mc[c][t] = t == 0 ? 16384 : 0;
         mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
      end
   endtask

   task automatic set_coef(input logic [3:0] a, input logic signed [17:0] d);
      if (a < 10) mc[a/5][a%5] = int'(d);
   endtask

   function automatic logic [31:0] model_step(input int a0, input int a1);
      int xs[2];
      longint acc, q;
      logic [31:0] r;
      xs[0] = a0; xs[1] = a1; r = '0;
      for (int c = 0; c < 2; c++) begin
         acc = longint'(mc[c][0]) * xs[c] + longint'(mc[c][1]) * mx1[c] + longint'(mc[c][2]) * mx2[c]
             - longint'(mc[c][3]) * my1[c] - longint'(mc[c][4]) * my2[c];
         q = (acc + 8192) >>> 14;
         if (q > 32767) q = 32767;
         if (q < -32768) q = -32768;
         mx2[c] = mx1[c]; mx1[c] = xs[c]; my2[c] = my1[c]; my1[c] = int'(q);
         r[c*16 +: 16] = q[15:0];
      end
      return r;
   endfunction

   task automatic cfg_write(input logic [3:0] a, input logic signed [17:0] d, input logic exp_err);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
      chk("cfg_err_idle", cfg_err, exp_err);
      if (!exp_err) set_coef(a, d);
   endtask

   // ovr_at>0: second strobe at edge E(ovr_at); cfg_at>=0: write sampled at E(cfg_at)
   task automatic run(input logic signed [15:0] a0, input logic signed [15:0] a1, input int ovr_at,
                      input int cfg_at, input logic [3:0] ca, input logic signed [17:0] cd);
      int vcnt = 0, ocnt = 0, ecnt = 0, vcyc = -1;
      @(negedge clk);
      din = {a1, a0}; sample_en = 1'b1;
      if (cfg_at == 0) begin
         cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
         set_coef(ca, cd);
      end
      exp_q.push_back(model_step(int'(a0), int'(a1)));
      @(negedge clk);
      sample_en = 1'b0; cfg_we = 1'b0; din = 32'hDEAD_BEEF;
      chk("busy_after_e0", busy, 1);
      for (int c = 0; c <= 16; c++) begin
         if (out_valid) begin
            vcnt++; vcyc = c;
            if (exp_q.size() == 0) chk("queue_empty", 1, 0);
            else chk("out", dout, exp_q.pop_front());
         end
         if (overrun) ocnt++;
         if (cfg_err) ecnt++;
         sample_en = ovr_at > 0 && c == ovr_at - 1;
         cfg_we = cfg_at > 0 && c == cfg_at - 1;
         cfg_addr = ca; cfg_data = cd;
         @(negedge clk);
      end
      chk("valid_count", vcnt, 1);
      chk("latency", vcyc + 1, 13);
      chk("overrun_count", ocnt, ovr_at > 0 ? 1 : 0);
      chk("cfg_err_count", ecnt, cfg_at > 0 ? 1 : 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      int vcnt;
      model_reset();
      #2;
      chk("rst_out", dout, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {overrun, cfg_err}, 0);
      @(negedge clk);
      reset = 1'b0;

      run(16'sd5000, -16'sd1234, 0, -1, 4'd0, 18'sd0);

      @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
      model_reset();
      cfg_write(4'd0, 18'sd8192, 1'b0);
      cfg_write(4'd1, 18'sd8192, 1'b0);
      run(16'sd1000, 16'sd77, 0, -1, 4'd0, 18'sd0);
      run(16'sd3000, -16'sd55, 0, -1, 4'd0, 18'sd0);

      cfg_write(4'd0, 18'sd131071, 1'b0);
      cfg_write(4'd1, 18'sd0, 1'b0);
      run(16'sd32767, 16'sd1, 0, -1, 4'd0, 18'sd0);
      run(-16'sd32768, -16'sd1, 0, -1, 4'd0, 18'sd0);
      cfg_write(4'd0, 18'sd16384, 1'b0);

      run(16'sd111, -16'sd222, 3, -1, 4'd0, 18'sd0);
      run(16'sd300, 16'sd400, 0, 5, 4'd5, 18'sd0);
      run(-16'sd7, 16'sd9, 0, -1, 4'd0, 18'sd0);
      cfg_write(4'd10, 18'sd5, 1'b1);
      run(16'sd1000, 16'sd1000, 0, 0, 4'd5, 18'sd8192);
      run(16'sd0, -16'sd3, 0, -1, 4'd0, 18'sd0);

      @(negedge clk);
      din = {16'sd2222, 16'sd1111}; sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_out", dout, 0);
      chk("midrst_valid", out_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      vcnt = 0;
      for (int c = 0; c < 14; c++) begin
         if (out_valid) vcnt++;
         @(negedge clk);
      end
      chk("midrst_no_valid", vcnt, 0);
      run(16'sd4321, -16'sd4321, 0, -1, 4'd0, 18'sd0);
      chk("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
